// File: rtl/clk_rst_seq.sv
// Per-domain clock/reset sequencer.
// Turns the software clock-enable / reset requests for one domain into a
// clock-gate enable and domain reset such that the clock always runs for a
// settle period before reset is released, reset is held for a minimum number
// of running cycles, and a PLL lock loss pushes the domain back into reset.
//
// Ports:
//   clk_i, arst_ni  - system clock, asynchronous active-low reset
//   clk_en_i        - requested clock enable (sync to clk_i)
//   rst_ni          - requested domain reset, active-low (sync to clk_i)
//   pll_locked_i    - PLL lock status (asynchronous, synchronized here)
//   clk_en_o        - clock-gate enable to the domain
//   rst_no          - domain reset, active-low
//   busy_o          - high while settling or holding reset
//   lock_err_o      - one-cycle pulse on lock loss while running
//   state_o         - current state encoding
module clk_rst_seq #(
  parameter int unsigned CLK_SETTLE_CYCLES = 16,
  parameter int unsigned RST_HOLD_CYCLES   = 8,
  parameter bit          USE_PLL_LOCK      = 1'b1
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       clk_en_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  output logic       clk_en_o,
  output logic       rst_no,
  output logic       busy_o,
  output logic       lock_err_o,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_MAX = (CLK_SETTLE_CYCLES > RST_HOLD_CYCLES) ?
                                    CLK_SETTLE_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CLK_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    SETTLE   = 3'd1,
    RST_HOLD = 3'd2,
    RUN      = 3'd3,
    GATED    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lock_sync_q;
  logic             lock_ok;
  logic             lock_err_d;

  // Two-flop synchronizer for the asynchronous lock status.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked_i};
    end
  end

  assign lock_ok = USE_PLL_LOCK ? lock_sync_q[1] : 1'b1;

  // Next-state, counter and lock-error pulse.
  always_comb begin
    state_d    = state_q;
    lock_err_d = 1'b0;

    unique case (state_q)
      OFF: begin
        if (clk_en_i) state_d = SETTLE;
      end
      SETTLE: begin
        if (!clk_en_i)                          state_d = OFF;
        else if (cnt_q >= SETTLE_LAST && lock_ok) state_d = RST_HOLD;
      end
      RST_HOLD: begin
        if (cnt_q >= HOLD_LAST && lock_ok) begin
          if (!clk_en_i)   state_d = OFF;
          else if (rst_ni) state_d = RUN;
        end
      end
      RUN: begin
        // Reset is always entered with the clock still running.
        if (!lock_ok) begin
          state_d    = RST_HOLD;
          lock_err_d = 1'b1;
        end else if (!rst_ni) begin
          state_d = RST_HOLD;
        end else if (!clk_en_i) begin
          state_d = GATED;
        end
      end
      GATED: begin
        // Domain flops are async-reset, so reset may be applied while gated.
        if (!rst_ni)                  state_d = OFF;
        else if (clk_en_i && lock_ok) state_d = RUN;
      end
      default: state_d = OFF;
    endcase

    // Restart on entry to a timed phase, otherwise count up and saturate.
    if ((state_d != state_q) && ((state_d == SETTLE) || (state_d == RST_HOLD))) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter and Moore outputs registered from the next state.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      clk_en_o   <= 1'b0;
      rst_no     <= 1'b0;
      busy_o     <= 1'b0;
      lock_err_o <= 1'b0;
      state_o    <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_en_o   <= (state_d == SETTLE) || (state_d == RST_HOLD) || (state_d == RUN);
      rst_no     <= (state_d == RUN) || (state_d == GATED);
      busy_o     <= (state_d == SETTLE) || (state_d == RST_HOLD);
      lock_err_o <= lock_err_d;
      state_o    <= state_d;
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Testbench for clk_rst_seq (default parameters).
// Stimulus drives inputs on the falling edge and queues the expected state
// for specific future rising edges; a monitor samples 1 ns after every rising
// edge and compares against the queue head for that cycle.
module tb_clk_rst_seq;

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_GATED  = 3'd4;

  logic       clk_i = 1'b0;
  logic       arst_ni;
  logic       clk_en_i;
  logic       rst_ni;
  logic       pll_locked_i;
  logic       clk_en_o;
  logic       rst_no;
  logic       busy_o;
  logic       lock_err_o;
  logic [2:0] state_o;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       lerr;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  clk_rst_seq dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .clk_en_i     (clk_en_i),
    .rst_ni       (rst_ni),
    .pll_locked_i (pll_locked_i),
    .clk_en_o     (clk_en_o),
    .rst_no       (rst_no),
    .busy_o       (busy_o),
    .lock_err_o   (lock_err_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected output vector {state, clk_en, rst_n, busy, lock_err} for a state.
  function automatic logic [6:0] exp_vec(input logic [2:0] st, input logic lerr);
    logic ce, rn, bz;
    ce = (st == S_SETTLE) || (st == S_HOLD) || (st == S_RUN);
    rn = (st == S_RUN) || (st == S_GATED);
    bz = (st == S_SETTLE) || (st == S_HOLD);
    return {st, ce, rn, bz, lerr};
  endfunction

  task automatic check(input string name, input logic [2:0] st, input logic lerr);
    logic [6:0] act, req;
    act = {state_o, clk_en_o, rst_no, busy_o, lock_err_o};
    req = exp_vec(st, lerr);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got {st,ce,rn,busy,lerr}=%b required=%b", name, cyc, act, req);
    end
  endtask

  // Queue an expectation for the off-th rising edge from now (off=1 is next).
  task automatic push(input int off, input logic [2:0] st, input logic lerr, input string name);
    exp_t e;
    e.cyc  = cyc + off;
    e.st   = st;
    e.lerr = lerr;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Expected power-up / re-start sequence from OFF with requests high.
  task automatic push_powerup(input string name);
    for (int k = 1; k <= 25; k++) begin
      if (k <= 16)      push(k, S_SETTLE, 1'b0, name);
      else if (k <= 24) push(k, S_HOLD, 1'b0, name);
      else              push(k, S_RUN, 1'b0, name);
    end
  endtask

  // Monitor: one sample per cycle, compared with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
        end else begin
          check(e.name, e.st, e.lerr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    arst_ni      = 1'b0;
    clk_en_i     = 1'b1;
    rst_ni       = 1'b1;
    pll_locked_i = 1'b1;
    #2;
    check("reset_state", S_OFF, 1'b0);
    wait_cyc(2);

    // Power-up: clk_en at e0, rst_no 24 cycles later.
    arst_ni = 1'b1;
    push_powerup("powerup");
    wait_cyc(25);

    // Lock loss in RUN, restored after 6 cycles.
    pll_locked_i = 1'b0;
    push(1, S_RUN, 1'b0, "lockdrop_run");
    push(2, S_RUN, 1'b0, "lockdrop_run");
    push(3, S_HOLD, 1'b1, "lockdrop_err");
    for (int k = 4; k <= 10; k++) push(k, S_HOLD, 1'b0, "lockdrop_hold");
    push(11, S_RUN, 1'b0, "lockdrop_rerun");
    wait_cyc(6);
    pll_locked_i = 1'b1;
    wait_cyc(5);

    // Gate and ungate the clock.
    clk_en_i = 1'b0;
    push(1, S_GATED, 1'b0, "gate");
    push(2, S_GATED, 1'b0, "gate_stay");
    wait_cyc(2);
    clk_en_i = 1'b1;
    push(1, S_RUN, 1'b0, "ungate");
    wait_cyc(1);

    // Gate, then reset while gated.
    clk_en_i = 1'b0;
    push(1, S_GATED, 1'b0, "gate2");
    wait_cyc(1);
    rst_ni = 1'b0;
    push(1, S_OFF, 1'b0, "gated_rst");
    push(2, S_OFF, 1'b0, "gated_rst_stay");
    wait_cyc(2);

    // Settle with no lock for 40 cycles, then lock.
    pll_locked_i = 1'b0;
    wait_cyc(3);
    clk_en_i = 1'b1;
    rst_ni   = 1'b1;
    for (int k = 1; k <= 40; k++) push(k, S_SETTLE, 1'b0, "nolock_settle");
    wait_cyc(40);
    pll_locked_i = 1'b1;
    push(1, S_SETTLE, 1'b0, "lockrise_sync");
    push(2, S_SETTLE, 1'b0, "lockrise_sync");
    for (int k = 3; k <= 10; k++) push(k, S_HOLD, 1'b0, "lockrise_hold");
    push(11, S_RUN, 1'b0, "lockrise_run");
    wait_cyc(11);

    // Drop clock enable and reset together in RUN.
    clk_en_i = 1'b0;
    rst_ni   = 1'b0;
    for (int k = 1; k <= 8; k++) push(k, S_HOLD, 1'b0, "both_drop_hold");
    push(9, S_OFF, 1'b0, "both_drop_off");
    wait_cyc(9);

    // Async reset mid-settle (cnt=5), then full restart.
    clk_en_i = 1'b1;
    rst_ni   = 1'b1;
    for (int k = 1; k <= 6; k++) push(k, S_SETTLE, 1'b0, "pre_arst_settle");
    wait_cyc(6);
    arst_ni = 1'b0;
    #1;
    check("arst_immediate", S_OFF, 1'b0);
    wait_cyc(1);
    check("arst_held", S_OFF, 1'b0);
    arst_ni = 1'b1;
    push_powerup("restart");
    wait_cyc(25);

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk_i);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Per-domain clock/reset sequencer placed directly downstream of the system control register block. It takes the raw clock-enable and reset requests written by software (`*_clk_en_o`/`*_rst_no` of the system control block) together with that domain's PLL lock status. It drives the domain's clock-gate enable and reset so that:

- the clock always runs for a settle period before reset release;
- reset is held for a minimum number of running clock cycles;
- a PLL lock loss forces the domain back into reset.

One instance is used per domain (E core, P core, core link, sys link, periph link).

## Interface
- `CLK_SETTLE_CYCLES`, default 16: minimum cycles with clock enabled and reset asserted before the reset-hold phase begins; must be ≥1.
- `RST_HOLD_CYCLES`, default 8: minimum cycles reset stays asserted with clock running before release; must be ≥1.
- `USE_PLL_LOCK`, default 1: 1 = lock status gates sequencing; 0 = `pll_locked_i` is ignored and treated as 1.
- `clk_i` input 1: system clock.
- `arst_ni` input 1: reset, asynchronous, active-low.
- `clk_en_i` input 1: requested clock enable (synchronous to `clk_i`).
- `rst_ni` input 1: requested domain reset, active-low (synchronous to `clk_i`).
- `pll_locked_i` input 1: PLL lock, asynchronous; passed through a 2-flop synchronizer to give `lock_ok`.
- `clk_en_o` output 1: clock-gate enable to the domain.
- `rst_no` output 1: domain reset, active-low.
- `busy_o` output 1: high while in SETTLE or RST_HOLD.
- `lock_err_o` output 1: one-cycle pulse when lock is lost in RUN.
- `state_o` output 3: current state encoding.

## Operation
- States and encodings: OFF=0, SETTLE=1, RST_HOLD=2, RUN=3, GATED=4.
- Moore outputs, decoded from the state register:
  - `clk_en_o` = 1 in SETTLE, RST_HOLD and RUN.
  - `rst_no` = 1 in RUN and GATED.
- Counter `cnt`:
  - Width is `$clog2(max(CLK_SETTLE_CYCLES, RST_HOLD_CYCLES)+1)`.
  - Cleared to 0 on every transition into SETTLE or RST_HOLD.
  - Otherwise increments, saturating at its maximum.
- OFF:
  - `clk_en_i`=1 → SETTLE, regardless of `rst_ni`.
- SETTLE:
  - `clk_en_i`=0 → OFF.
  - Else, if `cnt` ≥ `CLK_SETTLE_CYCLES`-1 and `lock_ok` → RST_HOLD.
  - Else stay. The counter keeps saturating while waiting for lock.
- RST_HOLD: when `cnt` ≥ `RST_HOLD_CYCLES`-1 and `lock_ok`:
  - `clk_en_i`=0 → OFF.
  - Else, `rst_ni`=1 → RUN.
  - Else stay, holding reset indefinitely.
  - Before the hold count completes, stay regardless of the requests.
- RUN, in priority order:
  - `lock_ok`=0 → RST_HOLD, with `lock_err_o`=1 for exactly one cycle, coincident with the first RST_HOLD cycle.
  - Else `rst_ni`=0 → RST_HOLD. This applies even if `clk_en_i`=0: reset is always applied with the clock running.
  - Else `clk_en_i`=0 → GATED.
- GATED:
  - `rst_ni`=0 → OFF. Reset is asserted while the clock stays gated; domain flops are async-reset.
  - Else `clk_en_i`=1 and `lock_ok` → RUN.
  - Else stay.
- With `USE_PLL_LOCK`=0, `lock_ok` is constantly 1 and `lock_err_o` is never asserted.

## Timing
- Reset values: state OFF, `clk_en_o`=0, `rst_no`=0, `busy_o`=0, `lock_err_o`=0, `state_o`=0, `cnt`=0, synchronizer flops 0.
- The system control block resets its link requests to 1, so the link domains come up automatically after `arst_ni` release.
- Request latency: a request change sampled at edge e0 changes the outputs after e0. There is one registered stage and no combinational input-to-output path.
- Power-up, requests high and lock stable:
  - Edge e0 (OFF sees `clk_en_i`=1): `clk_en_o` rises.
  - Edge e_N, N=`CLK_SETTLE_CYCLES`: RST_HOLD entered.
  - Edge e_{N+M}, M=`RST_HOLD_CYCLES`: `rst_no` rises.
  - With the defaults, `rst_no` rises 24 cycles after `clk_en_o`.
- Lock path: `pll_locked_i` reaches `lock_ok` 2 edges after it changes. A lock drop is therefore seen in RUN at the 3rd edge, where RUN → RST_HOLD occurs.
- Asynchronous `arst_ni` assertion mid-sequence forces the reset values immediately, independent of the clock.
- Request toggles shorter than one cycle are not filtered. Each sampled value acts per the transition rules.

## Test plan
- Power-up, both requests held high, `pll_locked_i`=1, defaults: `clk_en_o`=1 at e0; `rst_no`=1 exactly 24 cycles later; `busy_o` high for 24 cycles; final state 3.
- Requests high, lock held 0 for 40 cycles then 1: state stays SETTLE with `rst_no`=0; RST_HOLD is entered 2 cycles after lock rises; `rst_no` rises 8 cycles after that.
- RUN, drop `pll_locked_i` → `lock_err_o` is a single-cycle pulse 3 edges later and `rst_no`=0; restore lock → RUN again ≥8 cycles later.
- RUN, set `clk_en_i`=0 → GATED (`clk_en_o`=0, `rst_no`=1). Then:
  - `clk_en_i`=1 → RUN the next cycle.
  - Or `rst_ni`=0 while gated → OFF, with both outputs 0.
- RUN, drop `clk_en_i` and `rst_ni` in the same cycle → `rst_no`=0 with `clk_en_o`=1 for 8 cycles, then `clk_en_o`=0, state OFF.
- Assert `arst_ni` mid-SETTLE (`cnt`=5) → outputs 0 immediately; after release, the full 24-cycle sequence repeats from `cnt`=0.
